// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared definitions for the FIFO write-port arbiter.
//   - state_e   : arbiter FSM encoding (IDLE / GRANT)
//   - cnt_width : width of a counter that must hold 0..max_burst inclusive
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Returns a one-hot selection of the
//   first set request bit found searching upward, with wrap, starting at
//   i_ptr+1.
//   Ports:
//     i_req  [NUM_REQ]  request vector
//     i_ptr  [PTR_W]    index of the most recently served requester
//     o_pick [NUM_REQ]  one-hot winner, all-zero when i_req is zero
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_pick
);

  logic [PTR_W:0]       start;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [NUM_REQ-1:0]   oh_rot;
  logic [2*NUM_REQ-1:0] pick_dbl;
  logic                 found;

  // Rotate so that requester (ptr+1) lands at bit 0; the doubled vector
  // supplies the wrapped-around bits.
  assign start   = {1'b0, i_ptr} + (PTR_W+1)'(1);
  assign req_dbl = {i_req, i_req} >> start;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  always_comb begin
    oh_rot = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_rot[i] && !found) begin
        oh_rot[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  // Undo the rotation: the upper half of the shifted doubled vector holds
  // the winner back in original bit order.
  assign pick_dbl = {oh_rot, oh_rot} << start;
  assign o_pick   = pick_dbl[2*NUM_REQ-1:NUM_REQ];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing the async FIFO write port among NUM_REQ
//   requesters in the write-clock domain. A grant lasts for one packet or
//   MAX_BURST beats, whichever ends first, followed by a one-cycle bubble.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no owner; pick next requester when any valid is high
//   ST_GRANT | owner in grant_q may write while FIFO not full
//
//   Ports:
//     i_clk, i_rst_n   FIFO write clock, async active-low reset
//     i_req_valid/data/last, o_req_ready   per-requester beat interface
//     i_fifo_full      FIFO full flag
//     o_fifo_wr_en, o_fifo_wr_data         FIFO write side
//     o_grant          one-hot current owner (zero when idle)
//     o_busy           high in ST_GRANT
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_last,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic                          i_fifo_full,
  output logic                          o_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         o_fifo_wr_data,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_width(MAX_BURST);

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [NUM_REQ-1:0]    pick;
  logic [PTR_W-1:0]      owner_idx;
  logic                  owner_valid;
  logic                  owner_last;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  busy;
  logic                  wr_en;
  logic [CNT_W-1:0]      cnt_d;
  logic                  grant_end;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .i_req  (i_req_valid),
    .i_ptr  (ptr_q),
    .o_pick (pick)
  );

  // Everything about the owner is derived from the registered one-hot grant,
  // so the write path never depends on the arbitration logic.
  always_comb begin
    owner_idx = '0;
    wr_data   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) owner_idx = PTR_W'(k);
      wr_data = wr_data | (i_req_data[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[k]}});
    end
  end

  assign owner_valid = |(i_req_valid & grant_q);
  assign owner_last  = |(i_req_last & grant_q);
  assign busy        = (state_q == ST_GRANT);
  assign wr_en       = busy && owner_valid && !i_fifo_full;
  assign cnt_d       = cnt_q + CNT_W'(1);
  // cnt_d is the beat count including the current beat, so the grant ends
  // on exactly the MAX_BURST-th beat and the counter never exceeds it.
  assign grant_end   = wr_en && (owner_last || (cnt_d == CNT_W'(MAX_BURST)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|i_req_valid) begin
            grant_q <= pick;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (grant_end) begin
            grant_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= owner_idx;
            state_q <= ST_IDLE;
          end else if (wr_en) begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign o_grant        = grant_q;
  assign o_busy         = busy;
  assign o_req_ready    = (busy && !i_fifo_full) ? grant_q : '0;
  assign o_fifo_wr_en   = wr_en;
  assign o_fifo_wr_data = wr_data;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 4;
  localparam int MB = 8;

  logic           clk;
  logic           rst_n;
  logic [NR-1:0]  req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_last;
  logic [NR-1:0]  req_ready;
  logic           fifo_full;
  logic           wr_en;
  logic [DW-1:0]  wr_data;
  logic [NR-1:0]  grant;
  logic           busy;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req_valid    (req_valid),
    .i_req_data     (req_data),
    .i_req_last     (req_last),
    .o_req_ready    (req_ready),
    .i_fifo_full    (fifo_full),
    .o_fifo_wr_en   (wr_en),
    .o_fifo_wr_data (wr_data),
    .o_grant        (grant),
    .o_busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int        req;
    logic [3:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] src_q[NR][$];   // {last, data} per requester
  int         wr_cyc[$];
  int         total = 0;
  int         bad   = 0;
  int         cycle = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    logic [4:0] b;
    for (int k = 0; k < NR; k++) begin
      if (src_q[k].size() > 0) begin
        b = src_q[k][0];
        req_valid[k]           = 1'b1;
        req_last[k]            = b[4];
        req_data[k*DW +: DW]   = b[3:0];
      end else begin
        req_valid[k]           = 1'b0;
        req_last[k]            = 1'b0;
        req_data[k*DW +: DW]   = '0;
      end
    end
  endtask

  task automatic push_exp(input int r, input logic [3:0] d);
    exp_t e;
    e.req  = r;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // One clock: sample at negedge, score writes, complete handshakes,
  // advance past the rising edge and re-drive requester inputs.
  task automatic cyc(output bit wrote);
    exp_t e;
    logic [NR-1:0] acc;
    @(negedge clk);
    wrote = 1'b0;
    if ((req_ready & ~grant) != '0) check("ready_non_owner", 32'(req_ready), 32'(req_ready & grant));
    if (fifo_full) begin
      check("full_wr_en", 32'(wr_en), 0);
      check("full_ready", 32'(req_ready), 0);
    end
    if (wr_en) begin
      wrote = 1'b1;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(wr_data), 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_data", 32'(wr_data), 32'(e.data));
        check("wr_owner", 32'(grant), 32'(1) << e.req);
      end
    end
    acc = req_ready & req_valid;
    for (int k = 0; k < NR; k++)
      if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
    @(posedge clk);
    #1;
    cycle++;
    drive();
  endtask

  task automatic expect_writes(input int n, input int budget);
    bit w;
    int got;
    got = 0;
    wr_cyc.delete();
    for (int i = 0; i < budget && got < n; i++) begin
      cyc(w);
      if (w) begin
        wr_cyc.push_back(cycle - 1);
        got++;
      end
    end
    check("write_count", 32'(got), 32'(n));
  endtask

  task automatic check_gaps(input string tag, input int g[$]);
    for (int i = 0; i < g.size(); i++)
      if (i + 1 < wr_cyc.size()) check(tag, 32'(wr_cyc[i+1] - wr_cyc[i]), 32'(g[i]));
  endtask

  initial begin
    bit   w;
    int   gaps[$];
    int   c0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    rst_n     = 1'b0;

    // Reset held with every requester valid
    src_q[0].push_back({1'b1, 4'd1});
    src_q[0].push_back({1'b1, 4'd5});
    src_q[1].push_back({1'b1, 4'd2});
    src_q[2].push_back({1'b1, 4'd3});
    src_q[3].push_back({1'b1, 4'd4});
    push_exp(0, 4'd1); push_exp(1, 4'd2); push_exp(2, 4'd3);
    push_exp(3, 4'd4); push_exp(0, 4'd5);
    drive();
    #1;
    for (int i = 0; i < 2; i++) begin
      cyc(w);
      check("rst_grant", 32'(grant), 0);
      check("rst_wr_en", 32'(wr_en), 0);
      check("rst_ready", 32'(req_ready), 0);
      check("rst_busy", 32'(busy), 0);
    end
    rst_n = 1'b1;
    cyc(w);
    check("first_grant", 32'(grant), 32'b0001);

    // Round-robin, single-beat packets: one bubble between grants
    expect_writes(5, 40);
    gaps = '{2, 2, 2, 2};
    check_gaps("rr_gap", gaps);
    check("rr_exp_drained", 32'(exp_q.size()), 0);
    repeat (2) cyc(w);

    // Packet hold: req1 3-beat packet while req2 waits
    src_q[1].push_back({1'b0, 4'd1});
    src_q[1].push_back({1'b0, 4'd2});
    src_q[1].push_back({1'b1, 4'd3});
    src_q[2].push_back({1'b1, 4'd9});
    push_exp(1, 4'd1); push_exp(1, 4'd2); push_exp(1, 4'd3); push_exp(2, 4'd9);
    drive();
    expect_writes(4, 40);
    gaps = '{1, 1, 2};
    check_gaps("hold_gap", gaps);
    repeat (2) cyc(w);

    // Park the pointer on req3, then req0 streams 12 beats against req3
    src_q[3].push_back({1'b1, 4'd7});
    push_exp(3, 4'd7);
    drive();
    expect_writes(1, 20);
    repeat (2) cyc(w);
    for (int i = 0; i < 12; i++) begin
      src_q[0].push_back({(i == 11), 4'(i)});
      if (i == 8) push_exp(3, 4'd15);
      push_exp(0, 4'(i));
    end
    src_q[3].push_back({1'b1, 4'd15});
    drive();
    expect_writes(13, 80);
    gaps = '{1, 1, 1, 1, 1, 1, 1, 2, 2, 1, 1, 1};
    check_gaps("burst_gap", gaps);
    repeat (2) cyc(w);

    // Full back-pressure mid-packet: 10-beat packet from req1
    for (int i = 1; i <= 10; i++) begin
      src_q[1].push_back({(i == 10), 4'(i)});
      push_exp(1, 4'(i));
    end
    drive();
    expect_writes(2, 20);
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(w);
      check("full_grant_held", 32'(grant), 32'b0010);
    end
    fifo_full = 1'b0;
    c0 = cycle;
    expect_writes(8, 40);
    if (wr_cyc.size() > 0) check("full_resume_cycle", 32'(wr_cyc[0]), 32'(c0));
    gaps = '{1, 1, 1, 1, 1, 2, 1};
    check_gaps("full_gap", gaps);
    repeat (2) cyc(w);

    // Async reset during a GRANT of req2 with req0 waiting
    for (int i = 1; i <= 5; i++) src_q[2].push_back({(i == 5), 4'(i)});
    src_q[0].push_back({1'b1, 4'd12});
    push_exp(2, 4'd1); push_exp(2, 4'd2);
    drive();
    expect_writes(2, 20);
    check("pre_reset_grant", 32'(grant), 32'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_grant", 32'(grant), 0);
    check("async_busy", 32'(busy), 0);
    check("async_wr_en", 32'(wr_en), 0);
    check("async_ready", 32'(req_ready), 0);
    exp_q.delete();
    push_exp(0, 4'd12);
    push_exp(2, 4'd3); push_exp(2, 4'd4); push_exp(2, 4'd5);
    cyc(w);
    rst_n = 1'b1;
    cyc(w);
    check("post_reset_grant", 32'(grant), 32'b0001);
    expect_writes(4, 40);
    check("final_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the async FIFO between NUM_REQ requesters in the FIFO write-clock domain.
- Uses round-robin arbitration. A grant is held for a whole packet, or until MAX_BURST beats, whichever comes first.
- Drives the FIFO write enable and write data. Back-pressures requesters from the FIFO full flag.
- Sits directly in front of the FIFO write side and is clocked by the FIFO write clock.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 4, FIFO data width; must match the FIFO instance.
- MAX_BURST, 8, maximum beats per grant before forced re-arbitration (1..255).

Ports:
- i_clk  input  1  FIFO write clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req_valid  input  NUM_REQ  per-requester beat valid.
- i_req_data  input  NUM_REQ*DATA_WIDTH  packed beats; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_req_last  input  NUM_REQ  last beat of a packet; qualified by valid.
- o_req_ready  output  NUM_REQ  beat accepted when valid and ready are both high.
- i_fifo_full  input  1  FIFO full flag (write-clock domain).
- o_fifo_wr_en  output  1  FIFO write enable.
- o_fifo_wr_data  output  DATA_WIDTH  FIFO write data.
- o_grant  output  NUM_REQ  one-hot current owner; all-zero when idle.
- o_busy  output  1  high while in GRANT.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous assert, active-low on i_rst_n.
- Values during reset:
  - state = IDLE; o_grant = 0; beat counter = 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - All outputs are 0.
- State IDLE:
  - If any i_req_valid bit is high, register a one-hot grant to the first valid requester searching upward, with wrap, from pointer+1. Next state is GRANT.
  - Otherwise stay in IDLE.
  - Arbitration latency: 1 cycle from valid to o_grant.
- State GRANT, owner g:
  - o_req_ready[g] = !i_fifo_full. All other ready bits are 0.
  - o_fifo_wr_en = i_req_valid[g] && !i_fifo_full (combinational).
  - o_fifo_wr_data = slice g of i_req_data, muxed from the registered grant. Its value is don't-care when wr_en is 0.
  - A beat is a cycle with wr_en high. Each beat increments the beat counter.
- Exit from GRANT, on the cycle of the beat where i_req_last[g] = 1, or where the counter reaches MAX_BURST:
  - o_grant clears next cycle.
  - Counter resets to 0.
  - Pointer is set to g.
  - State returns to IDLE.
  - This gives a 1-cycle bubble between grants, even if other requesters are waiting.
- Grant hold rules:
  - The grant is held while the owner deasserts valid mid-packet. There is no timeout.
  - The grant is held while i_fifo_full is high. No beat is written and the counter does not advance.
  - A burst cut at MAX_BURST does not end the packet. The requester re-arbitrates and continues the packet in a later grant.
- Full handling: the arbiter never issues wr_en while i_fifo_full is high. The FIFO's own full guard is redundant, not relied upon.
- Non-owners: valid and last from non-owners are ignored and never cause writes.
- Counter: width $clog2(MAX_BURST+1). It never exceeds MAX_BURST.
- Reset mid-operation: an immediate return to reset values. Any partial packet is abandoned; upstream is responsible for recovery.

Decomposition:
- Package fifo_arb_pkg holds:
  - state encoding constants ST_IDLE = 1'b0 and ST_GRANT = 1'b1;
  - the counter-width function.
- Sub-module rr_pick (combinational):
  - inputs: request vector, pointer;
  - output: one-hot pick, via a doubled-vector rotate and priority search.
- The top level holds the FSM, the grant register, the pointer, the counter and the data mux.

Test Plan:
- Reset: hold i_rst_n = 0 with all valids high.
  - Required: o_grant = 0, wr_en = 0, ready = 0.
  - After release: o_grant = 4'b0001 one cycle after the first rising edge.
- Round-robin with all 4 valid and single-beat packets (last = 1):
  - Grant sequence is 0001, 0010, 0100, 1000, 0001.
  - There is a 1-cycle idle gap between grants; wr_data equals the granted slice.
- Packet hold: req1 sends 3 beats (data 1, 2, 3; last on beat 3) while req2 is valid throughout.
  - FIFO receives 1, 2, 3 contiguously.
  - Grant moves to req2 only after beat 3 plus the bubble.
- Burst cap: MAX_BURST = 8, req0 streams 12 beats with req3 valid.
  - Exactly 8 writes, then the grant passes to req3.
  - req0 regains the grant later and writes the remaining 4 beats.
- Full back-pressure: assert i_fifo_full for 5 cycles mid-packet.
  - wr_en = 0 and ready = 0 throughout; counter frozen; grant unchanged.
  - Writes resume the cycle after full drops, with no beat lost or duplicated.
- Async reset mid-packet: pulse i_rst_n low between clock edges during GRANT.
  - Outputs clear immediately, without waiting for a clock edge.
  - Pointer returns to NUM_REQ-1 and the next grant goes to requester 0.
